// File: rtl/armleocpu_cache_port_arbiter_if.sv
// Cache command handshake between two requesters, the arbiter and the cache.
// The slave modport is the arbiter's view. The master modport is the requester/cache side.
interface armleocpu_cache_port_arbiter_if;
  logic [3:0]  r0_cmd;
  logic [31:0] r0_address;
  logic [31:0] r0_store_data;
  logic        r0_done;
  logic [3:0]  r0_response;
  logic [31:0] r0_load_data;

  logic [3:0]  r1_cmd;
  logic [31:0] r1_address;
  logic [31:0] r1_store_data;
  logic        r1_done;
  logic [3:0]  r1_response;
  logic [31:0] r1_load_data;

  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic [31:0] c_store_data;
  logic        c_done;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;

  logic [1:0]  arb_grant;
  logic        arb_busy;

  modport slave (
    input  r0_cmd, r0_address, r0_store_data,
    output r0_done, r0_response, r0_load_data,
    input  r1_cmd, r1_address, r1_store_data,
    output r1_done, r1_response, r1_load_data,
    output c_cmd, c_address, c_store_data,
    input  c_done, c_response, c_load_data,
    output arb_grant, arb_busy
  );

  modport master (
    output r0_cmd, r0_address, r0_store_data,
    input  r0_done, r0_response, r0_load_data,
    output r1_cmd, r1_address, r1_store_data,
    input  r1_done, r1_response, r1_load_data,
    input  c_cmd, c_address, c_store_data,
    output c_done, c_response, c_load_data,
    input  arb_grant, arb_busy
  );
endinterface

// File: rtl/armleocpu_cache_port_arbiter.sv
// Round-robin arbiter sharing one cache command port between fetch (port 0) and data (port 1).
// The grant is locked until c_done. The next command is issued in the same cycle as the done.
module armleocpu_cache_port_arbiter #(
  parameter logic [3:0] CMD_NONE = 4'd0
) (
  input logic                          clk,
  input logic                          rst,
  armleocpu_cache_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   cand0, cand1, win_vld, win_id;
  logic   rearb, owned;
  logic   sel_vld, sel_id;
  logic [3:0] cmd_out;

  assign cand0   = (bus.r0_cmd != CMD_NONE);
  assign cand1   = (bus.r1_cmd != CMD_NONE);
  assign win_vld = cand0 | cand1;
  // On a tie the requester that did not win last time goes next.
  assign win_id  = (cand0 && cand1) ? ~last_grant : cand1;

  assign owned = (state == OWN0) || (state == OWN1);
  assign rearb = !owned || bus.c_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    if (rearb) begin
      if (win_vld) begin
        state_nxt      = win_id ? OWN1 : OWN0;
        last_grant_nxt = win_id;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    sel_vld          = 1'b0;
    sel_id           = 1'b0;
    cmd_out          = CMD_NONE;
    bus.c_address    = 32'h0;
    bus.c_store_data = 32'h0;
    bus.r0_done      = 1'b0;
    bus.r1_done      = 1'b0;
    bus.arb_grant    = 2'b00;
    if (!rst) begin
      if (rearb) begin
        sel_vld     = win_vld;
        sel_id      = win_id;
        bus.r0_done = bus.c_done && (state == OWN0);
        bus.r1_done = bus.c_done && (state == OWN1);
      end else begin
        sel_vld = 1'b1;
        sel_id  = (state == OWN1);
      end
      if (sel_vld) begin
        cmd_out          = sel_id ? bus.r1_cmd        : bus.r0_cmd;
        bus.c_address    = sel_id ? bus.r1_address    : bus.r0_address;
        bus.c_store_data = sel_id ? bus.r1_store_data : bus.r0_store_data;
        bus.arb_grant    = sel_id ? 2'b10 : 2'b01;
      end
    end
    bus.c_cmd    = cmd_out;
    bus.arb_busy = !rst && ((state != IDLE) || (cmd_out != CMD_NONE));
  end

  // Responses are broadcast; only the per-port done qualifies them.
  assign bus.r0_response  = bus.c_response;
  assign bus.r0_load_data = bus.c_load_data;
  assign bus.r1_response  = bus.c_response;
  assign bus.r1_load_data = bus.c_load_data;

`ifdef FORMAL_RULES
  a_owner0_stable: assert property (@(posedge clk) disable iff (rst)
    ($past(state == OWN0 && !bus.c_done) && !$past(rst)) |->
      ($stable(bus.r0_cmd) && $stable(bus.r0_address)));
  a_owner1_stable: assert property (@(posedge clk) disable iff (rst)
    ($past(state == OWN1 && !bus.c_done) && !$past(rst)) |->
      ($stable(bus.r1_cmd) && $stable(bus.r1_address)));
  a_cmd_stable: assert property (@(posedge clk) disable iff (rst)
    ($past(bus.c_cmd != CMD_NONE && !bus.c_done) && !$past(rst)) |->
      ($stable(bus.c_cmd) && $stable(bus.c_address)));
  a_no_spurious_done: assert property (@(posedge clk) disable iff (rst)
    ($past(bus.c_cmd == CMD_NONE) && !$past(rst)) |-> !bus.c_done);
`endif

endmodule
